fifo_burst_reader: RTL and testbench

- Read-side controller for the dual-clock FIFO.
- Lives entirely in the receive clock domain. Drives the FIFO `read_enable` from `fifo_empty` and `recv_data`.
- Turns host burst commands into a valid/ready output stream that marks the last word of each burst.
- Sits between the FIFO read port and downstream consumers (packet assembler, DMA sink).

---
 rtl/fifo_burst_reader_pkg.sv | 18 +
 rtl/fifo_burst_reader_if.sv | 37 +++
 rtl/fifo_skid_buffer.sv | 61 ++++++
 rtl/fifo_burst_reader.sv | 98 +++++++++
 tb/tb_fifo_burst_reader.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// fifo_pkg: shared types and default widths for the FIFO burst reader
// and its skid buffer.
//   state_t          - controller states
//   DATA_BUS_LENGTH  - default FIFO/output data width
//   LEN_WIDTH        - default burst-length command width
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DATA_BUS_LENGTH = 8;
  localparam int LEN_WIDTH       = 4;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: command, FIFO-read and output-stream signals of the
// burst reader.
//   master - the reader: drives cmd_ready, read_enable, out_*, burst_done, busy
//   slave  - the environment: host command source, FIFO read port, consumer
interface fifo_burst_reader_if
  import fifo_pkg::*;
#(
  parameter int data_bus_length = DATA_BUS_LENGTH,
  parameter int len_width       = LEN_WIDTH
) ();

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [len_width-1:0]       cmd_len;
  logic                       fifo_empty;
  logic [data_bus_length-1:0] recv_data;
  logic                       read_enable;
  logic                       out_valid;
  logic                       out_ready;
  logic [data_bus_length-1:0] out_data;
  logic                       out_last;
  logic                       burst_done;
  logic                       busy;

  modport master (
    input  cmd_valid, cmd_len, fifo_empty, recv_data, out_ready,
    output cmd_ready, read_enable, out_valid, out_data, out_last,
           burst_done, busy
  );

  modport slave (
    output cmd_valid, cmd_len, fifo_empty, recv_data, out_ready,
    input  cmd_ready, read_enable, out_valid, out_data, out_last,
           burst_done, busy
  );

endinterface

// File: rtl/fifo_skid_buffer.sv
// fifo_skid_buffer: 2-entry valid/ready buffer. The head entry drives the
// output straight from registers; the tail entry absorbs one extra word.
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - write handshake (in_ready low only when full)
//   in_data               - entry to store
//   out_valid/out_ready   - read handshake, out_data is the head entry
module fifo_skid_buffer #(
  parameter int width = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data
);

  logic [width-1:0] head_q, tail_q;
  logic             head_vld, tail_vld;
  logic             enq, deq;

  assign in_ready  = !tail_vld;
  assign enq       = in_valid && in_ready;
  assign deq       = head_vld && out_ready;
  assign out_valid = head_vld;
  assign out_data  = head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
    end else if (deq) begin
      if (tail_vld) begin
        head_q   <= tail_q;
        head_vld <= 1'b1;
        tail_vld <= enq;
        if (enq) tail_q <= in_data;
      end else if (enq) begin
        head_q   <= in_data;
        head_vld <= 1'b1;
      end else begin
        // Drained: clear the head so a stale last flag never lingers.
        head_q   <= '0;
        head_vld <= 1'b0;
      end
    end else if (enq) begin
      if (!head_vld) begin
        head_q   <= in_data;
        head_vld <= 1'b1;
      end else begin
        tail_q   <= in_data;
        tail_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side controller of the dual-clock FIFO, entirely in
// the receive domain. Accepts a burst command, pops cmd_len words from the
// FIFO and presents them as a valid/ready stream with out_last on the final
// word, then pulses burst_done.
//   recv_clk, recv_rst - clock, synchronous active-high reset
//   bus (master)       - cmd_valid/cmd_ready/cmd_len command channel,
//                        fifo_empty/recv_data/read_enable FIFO read port,
//                        out_valid/out_ready/out_data/out_last stream,
//                        burst_done pulse, busy status
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int data_bus_length = DATA_BUS_LENGTH,
  parameter int len_width       = LEN_WIDTH
) (
  input  logic                recv_clk,
  input  logic                recv_rst,
  fifo_burst_reader_if.master bus
);

  state_t                     state;
  logic [len_width-1:0]       remaining;
  logic                       burst_done_q;
  logic                       skid_in_ready;
  logic                       pop, pop_last, accept, last_hs;
  logic [data_bus_length:0]   head;

  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign last_hs  = bus.out_valid && bus.out_ready && bus.out_last;
  assign pop_last = (remaining == len_width'(1));

  // skid_in_ready is the "fewer than two buffered words" condition.
  assign pop = !recv_rst && (state == BURST) && !bus.fifo_empty &&
               (remaining != '0) && skid_in_ready;

  assign bus.read_enable = pop;
  assign bus.cmd_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.burst_done  = burst_done_q;
  assign bus.out_last    = head[data_bus_length];
  assign bus.out_data    = head[data_bus_length-1:0];

  fifo_skid_buffer #(.width(data_bus_length + 1)) u_skid (
    .clk       (recv_clk),
    .rst       (recv_rst),
    .in_valid  (pop),
    .in_ready  (skid_in_ready),
    .in_data   ({pop_last, bus.recv_data}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head)
  );

  always_ff @(posedge recv_clk) begin
    if (recv_rst) begin
      state        <= IDLE;
      remaining    <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // A zero-length burst completes without leaving IDLE.
            if (bus.cmd_len == '0) begin
              burst_done_q <= 1'b1;
            end else begin
              remaining <= bus.cmd_len;
              state     <= BURST;
            end
          end
        end
        BURST: begin
          if (pop) begin
            remaining <= remaining - 1'b1;
            if (pop_last) begin
              if (last_hs) begin
                state        <= DONE;
                burst_done_q <= 1'b1;
              end else begin
                state <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          if (last_hs) begin
            state        <= DONE;
            burst_done_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;
  import fifo_pkg::*;

  logic recv_clk = 1'b0;
  logic recv_rst = 1'b1;
  always #5 recv_clk = ~recv_clk;

  fifo_burst_reader_if bus ();

  fifo_burst_reader dut (
    .recv_clk (recv_clk),
    .recv_rst (recv_rst),
    .bus      (bus.master)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  // Environment FIFO contents (head at index 0).
  logic [7:0] fifo_q[$];

  // Reference model: burst in terms of words popped / accepted.
  bit         m_active, m_done;
  int         m_len, m_pop, m_acc;
  logic [7:0] m_words[$];

  // Observation logs for hand-computed checks.
  int         re_log[$], done_log[$], hs_cyc[$], acc_log[$];
  logic [7:0] out_log[$];
  bit         last_log[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.recv_data  = (fifo_q.size() == 0) ? 8'hEE : fifo_q[0];
  endtask

  task automatic clear_logs();
    re_log.delete(); done_log.delete(); hs_cyc.delete(); acc_log.delete();
    out_log.delete(); last_log.delete();
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    bit e_re, e_hs, e_acc, rst_s, env_pop, nd;
    logic [7:0] head;
    int len_s;
    @(negedge recv_clk);
    e_re  = !recv_rst && m_active && !m_done && !bus.fifo_empty &&
            (m_pop < m_len) && ((m_pop - m_acc) < 2);
    e_acc = !m_active && bus.cmd_valid;
    e_hs  = (m_words.size() > 0) && bus.out_ready;
    chk("read_enable", bus.read_enable, e_re);
    chk("busy", bus.busy, m_active);
    chk("cmd_ready", bus.cmd_ready, !m_active);
    chk("burst_done", bus.burst_done, m_done);
    chk("out_valid", bus.out_valid, m_words.size() > 0);
    if (m_words.size() > 0) begin
      chk("out_data", bus.out_data, m_words[0]);
      chk("out_last", bus.out_last, m_acc == m_len - 1);
    end
    if (bus.read_enable) re_log.push_back(cyc);
    if (bus.burst_done) done_log.push_back(cyc);
    if (bus.cmd_valid && bus.cmd_ready && !recv_rst) acc_log.push_back(cyc);
    if (bus.out_valid && bus.out_ready && !recv_rst) begin
      out_log.push_back(bus.out_data);
      last_log.push_back(bus.out_last);
      hs_cyc.push_back(cyc);
    end
    head    = bus.recv_data;
    env_pop = bus.read_enable;
    rst_s   = recv_rst;
    len_s   = int'(bus.cmd_len);
    @(posedge recv_clk);
    #1;
    cyc++;
    if (env_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (rst_s) begin
      m_active = 0; m_done = 0; m_len = 0; m_pop = 0; m_acc = 0;
      m_words.delete();
    end else begin
      nd = 0;
      if (m_done && m_active) m_active = 0;
      if (e_hs) begin
        void'(m_words.pop_front());
        m_acc++;
        if (m_acc == m_len) nd = 1;
      end
      if (e_re) begin
        m_words.push_back(head);
        m_pop++;
      end
      if (e_acc) begin
        if (len_s == 0) nd = 1;
        else begin
          m_active = 1; m_len = len_s; m_pop = 0; m_acc = 0;
        end
      end
      m_done = nd;
    end
    drive_fifo();
  endtask

  task automatic cmd(int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len[3:0];
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((m_active || m_done) && n < budget) begin
      step();
      n++;
    end
    if (m_active || m_done) begin
      tests++;
      failed++;
      $display("FAIL burst_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic push(logic [7:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  initial begin
    logic [7:0] exp6 [6];
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    drive_fifo();
    m_active = 0; m_done = 0; m_len = 0; m_pop = 0; m_acc = 0;
    @(posedge recv_clk);
    #1;
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_burst_done", bus.burst_done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_read_enable", bus.read_enable, 0);
    recv_rst = 1'b0;

    // Preloaded 4-word burst at full rate.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    bus.out_ready = 1'b1;
    clear_logs();
    cmd(4);
    wait_idle(30);
    chk("b4_pops", re_log.size(), 4);
    if (re_log.size() == 4 && acc_log.size() == 1) begin
      chk("b4_first_pop_lat", re_log[0], acc_log[0] + 1);
      chk("b4_pops_consec", re_log[3], re_log[0] + 3);
    end
    chk("b4_words", out_log.size(), 4);
    if (out_log.size() == 4) begin
      chk("b4_w0", out_log[0], 8'h11); chk("b4_w3", out_log[3], 8'h44);
      chk("b4_last0", last_log[0], 0); chk("b4_last3", last_log[3], 1);
      chk("b4_out_consec", hs_cyc[3], hs_cyc[0] + 3);
    end
    chk("b4_done_cnt", done_log.size(), 1);
    if (done_log.size() == 1 && hs_cyc.size() == 4)
      chk("b4_done_lat", done_log[0], hs_cyc[3] + 1);

    // FIFO runs dry mid-burst, refilled later.
    clear_logs();
    push(8'hA1);
    cmd(3);
    repeat (5) step();
    chk("dry_pops_early", re_log.size(), 1);
    chk("dry_busy", bus.busy, 1);
    push(8'hA2); push(8'hA3);
    wait_idle(30);
    chk("dry_pops", re_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("dry_w0", out_log[0], 8'hA1); chk("dry_w2", out_log[2], 8'hA3);
      chk("dry_last", last_log[2], 1);
    end else chk("dry_words", out_log.size(), 3);

    // Backpressure: two pops then stall, head held.
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      exp6[i] = 8'hC1 + 8'(i);
      push(exp6[i]);
    end
    bus.out_ready = 1'b0;
    cmd(6);
    repeat (10) step();
    chk("bp_pops", re_log.size(), 2);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_hold", bus.out_data, 8'hC1);
    bus.out_ready = 1'b1;
    wait_idle(40);
    chk("bp_words", out_log.size(), 6);
    if (out_log.size() == 6)
      for (int i = 0; i < 6; i++) chk("bp_order", out_log[i], exp6[i]);

    // Zero-length burst.
    clear_logs();
    cmd(0);
    step();
    step();
    chk("z_pops", re_log.size(), 0);
    chk("z_done_cnt", done_log.size(), 1);
    if (done_log.size() == 1 && acc_log.size() == 1)
      chk("z_done_lat", done_log[0], acc_log[0] + 1);
    chk("z_cmd_ready", bus.cmd_ready, 1);

    // Second command while busy is ignored.
    clear_logs();
    push(8'hD1); push(8'hD2); push(8'hD3);
    for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
    cmd(3);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 4'd5;
    repeat (3) step();
    bus.cmd_valid = 1'b0;
    wait_idle(30);
    chk("ign_pops", re_log.size(), 3);
    chk("ign_accepts", acc_log.size(), 1);
    chk("ign_done_cnt", done_log.size(), 1);
    chk("ign_fifo_left", fifo_q.size(), 5);
    fifo_q.delete();
    drive_fifo();

    // Reset after 2 of 5 pops.
    clear_logs();
    for (int i = 0; i < 5; i++) push(8'hB1 + 8'(i));
    cmd(5);
    n = 0;
    while (re_log.size() < 2 && n < 10) begin
      step();
      n++;
    end
    chk("rst_mid_pops", re_log.size(), 2);
    recv_rst = 1'b1;
    step();
    recv_rst = 1'b0;
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_cmd_ready", bus.cmd_ready, 1);
    chk("rst_mid_fifo_left", fifo_q.size(), 3);
    clear_logs();
    cmd(3);
    wait_idle(30);
    if (out_log.size() == 3) begin
      chk("rst_mid_w0", out_log[0], 8'hB3); chk("rst_mid_w1", out_log[1], 8'hB4);
      chk("rst_mid_w2", out_log[2], 8'hB5);
    end else chk("rst_mid_words", out_log.size(), 3);

    // Randomized traffic against the model.
    repeat (3000) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (fifo_q.size() < 24 && $urandom_range(0, 1) == 1) push(8'($urandom));
      bus.cmd_valid = ($urandom_range(0, 3) == 0);
      bus.cmd_len   = 4'($urandom_range(0, 15));
      recv_rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    recv_rst      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'($urandom));
    wait_idle(200);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
